// File: rtl/kgp_mem_pkg.sv
// Shared types and constants for the KGP-RISC data-memory responder.
// Holds the FSM state encoding and decode constants.
package kgp_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int          CNT_W       = 4;
  localparam logic [10:0] IO_ADDR_DEF = 11'h7FF;
  localparam logic [31:0] OOR_RDATA   = 32'h0000_0000;

endpackage

// File: rtl/kgp_dmem_array.sv
// Word-addressed data RAM: synchronous write, asynchronous read.
// Contents are never reset.
module kgp_dmem_array #(
  parameter int WORDS = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/kgp_dmem_responder.sv
// Data-port responder with wait states, one memory-mapped output
// register and a sticky out-of-range flag.
module kgp_dmem_responder
  import kgp_mem_pkg::*;
#(
  parameter int                ADDR_W      = 11,
  parameter int                MEM_WORDS   = 256,
  parameter int                WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(IO_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [31:0]       io_out,
  output logic              err
);

  localparam int IDX_W =
    (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W:0] MEM_LIM =
    (ADDR_W+1)'(MEM_WORDS);
  localparam logic [CNT_W-1:0] WS_LD =
    CNT_W'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       io_q, io_d;
  logic              err_q, err_d;

  logic              fire;
  logic              eff_we;
  logic [ADDR_W-1:0] eff_addr;
  logic [31:0]       eff_wdata;
  logic              is_io;
  logic              is_ram;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  // With zero wait states the access completes straight from IDLE,
  // so the live request is used instead of the latched copy.
  always_comb begin
    eff_we    = we_q;
    eff_addr  = addr_q;
    eff_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      eff_we    = req_we;
      eff_addr  = req_addr;
      eff_wdata = req_wdata;
    end
  end

  assign is_io  = (eff_addr == IO_ADDR);
  assign is_ram = !is_io && ({1'b0, eff_addr} < MEM_LIM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fire    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WS_LD;
          if (WS_LD == '0) begin
            state_d = ST_RESP;
            fire    = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d = ST_RESP;
          fire    = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stores and load data capture happen on the edge entering RESP.
  always_comb begin
    io_d    = io_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (fire) begin
      unique case (1'b1)
        is_io: begin
          if (eff_we) io_d = eff_wdata;
          else        rdata_d = io_q;
        end
        is_ram: begin
          if (!eff_we) rdata_d = ram_rdata;
        end
        default: begin
          err_d = 1'b1;
          if (!eff_we) rdata_d = OOR_RDATA;
        end
      endcase
    end
  end

  assign ram_we = fire && eff_we && is_ram && rst;

  kgp_dmem_array #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (eff_addr[IDX_W-1:0]),
    .wdata_i (eff_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      io_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      io_q    <= io_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign io_out     = io_q;
  assign err        = err_q;

endmodule

// File: tb/tb_kgp_dmem_responder.sv
// Directed bench: a WAIT_STATES=2 instance for the main sequence and
// a WAIT_STATES=0 instance for back-to-back throughput.
module tb_kgp_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [10:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] io_out;
  logic        err;

  logic        b_valid = 1'b0;
  logic        b_we = 1'b0;
  logic [10:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic        b_ready;
  logic        b_resp;
  logic [31:0] b_rdata;
  logic [31:0] b_io;
  logic        b_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kgp_dmem_responder #(
    .ADDR_W(11), .MEM_WORDS(256),
    .WAIT_STATES(2), .IO_ADDR(11'h7FF)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .io_out(io_out),
    .err(err)
  );

  kgp_dmem_responder #(
    .ADDR_W(11), .MEM_WORDS(256),
    .WAIT_STATES(0), .IO_ADDR(11'h7FF)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .req_ready(b_ready), .resp_valid(b_resp),
    .resp_rdata(b_rdata), .io_out(b_io),
    .err(b_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; inputs are scrambled after accept so only
  // the latched copy can produce the right result. Returns in the
  // RESP cycle with lat = cycles from the accept cycle.
  task automatic xfer(input logic we,
                      input logic [10:0] a,
                      input logic [31:0] d,
                      output logic [31:0] rd,
                      output int lat);
    int n;
    lat = -1;
    rd = '0;
    n = 0;
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    step();
    req_valid = 1'b0;
    req_we = ~we;
    req_addr = a ^ 11'h0F3;
    req_wdata = ~d;
    for (int i = 1; i <= 20; i++) begin
      if (resp_valid) begin
        lat = i;
        rd = resp_rdata;
        break;
      end
      step();
    end
  endtask

  logic [31:0] rd;
  int lat;
  int seen;

  initial begin
    step();
    step();
    rst = 1'b1;
    step();

    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp", 32'(resp_valid), 32'd0);
    check("rst_io", io_out, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);

    xfer(1'b1, 11'd5, 32'hCAFE_0001, rd, lat);
    check("st5_lat", 32'(lat), 32'd3);
    check("st5_ready", 32'(req_ready), 32'd0);
    step();
    check("st5_idle", 32'(req_ready), 32'd1);
    check("st5_resp_off", 32'(resp_valid), 32'd0);

    xfer(1'b0, 11'd5, 32'h0, rd, lat);
    check("ld5_lat", 32'(lat), 32'd3);
    check("ld5_data", rd, 32'hCAFE_0001);
    step();

    xfer(1'b1, 11'h7FF, 32'h0000_00A5, rd, lat);
    check("io_st_lat", 32'(lat), 32'd3);
    check("io_out_resp", io_out, 32'h0000_00A5);
    check("rdata_hold", resp_rdata, 32'hCAFE_0001);
    step();
    check("rdata_idle", resp_rdata, 32'hCAFE_0001);
    xfer(1'b0, 11'h7FF, 32'h0, rd, lat);
    check("io_ld", rd, 32'h0000_00A5);
    step();

    check("err_pre", 32'(err), 32'd0);
    xfer(1'b0, 11'd300, 32'h0, rd, lat);
    check("oor_data", rd, 32'd0);
    check("oor_err", 32'(err), 32'd1);
    step();
    xfer(1'b1, 11'd400, 32'h1234_5678, rd, lat);
    step();
    xfer(1'b0, 11'd5, 32'h0, rd, lat);
    check("oor_st_drop", rd, 32'hCAFE_0001);
    check("err_sticky", 32'(err), 32'd1);
    step();

    xfer(1'b1, 11'd6, 32'h1111_0006, rd, lat);
    step();
    xfer(1'b0, 11'd6, 32'h0, rd, lat);
    check("latch_ld6", rd, 32'h1111_0006);
    step();
    xfer(1'b1, 11'd7, 32'h7777_0007, rd, lat);
    step();

    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 11'd7;
    req_wdata = 32'hDEAD_BEEF;
    step();
    req_valid = 1'b0;
    check("mid_wait", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #2;
    check("rst_async", 32'(req_ready), 32'd1);
    step();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen++;
      step();
    end
    check("rst_no_resp", 32'(seen), 32'd0);
    check("rst2_io", io_out, 32'd0);
    check("rst2_err", 32'(err), 32'd0);
    check("rst2_rdata", resp_rdata, 32'd0);
    xfer(1'b0, 11'd7, 32'h0, rd, lat);
    check("ld7_kept", rd, 32'h7777_0007);
    step();

    b_valid = 1'b1;
    b_we = 1'b1;
    b_addr = 11'd3;
    b_wdata = 32'h0000_0033;
    check("z_ready0", 32'(b_ready), 32'd1);
    step();
    check("z_st_resp", 32'(b_resp), 32'd1);
    b_we = 1'b0;
    b_wdata = 32'h0;
    step();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("z_ready%0d", i), 32'(b_ready),
            (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("z_resp%0d", i), 32'(b_resp),
            (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 1)
        check($sformatf("z_data%0d", i), b_rdata,
              32'h0000_0033);
      step();
    end
    b_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
